// File: rtl/gate_unit_seq_if.sv
// Signal bundle between the gate-unit self-test sequencer and its environment
// (gate unit under test plus board-level test/status logic).
interface gate_unit_seq_if;
  logic       start;
  logic       a_o;
  logic       b_o;
  logic [5:0] y_i;
  logic       busy;
  logic       done;
  logic       pass;
  logic [5:0] fail_mask;
  logic [1:0] fail_vec;

  modport master (
    input  start, y_i,
    output a_o, b_o, busy, done, pass, fail_mask, fail_vec
  );

  modport slave (
    output start, y_i,
    input  a_o, b_o, busy, done, pass, fail_mask, fail_vec
  );
endinterface

// File: rtl/gate_unit_seq.sv
// Self-test sequencer for the two-input basic gate unit: walks {a,b}=00..11,
// checks the six gate outputs. Define GATE_SEQ_STOP_ON_FAIL_EN to end a run at the first failing vector.
module gate_unit_seq #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input logic             clk,
  input logic             rst,
  gate_unit_seq_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [7:0] LOAD = 8'(SETTLE_CYCLES - 1);

  state_t     r_state;
  logic [1:0] r_vec;
  logic [7:0] r_cnt;
  logic       r_a;
  logic       r_b;
  logic       r_busy;
  logic       r_done;
  logic       r_pass;
  logic [5:0] r_mask;
  logic [1:0] r_fvec;

  logic       w_accept;
  logic       w_last;
  logic [5:0] w_expected;
  logic [5:0] w_mismatch;

  // Truth table packed as {NAND, NOR, XOR, OR, AND, NOT a}.
  assign w_expected = {~(r_vec[1] & r_vec[0]), ~(r_vec[1] | r_vec[0]),
                       r_vec[1] ^ r_vec[0], r_vec[1] | r_vec[0],
                       r_vec[1] & r_vec[0], ~r_vec[1]};
  assign w_mismatch = bus.y_i ^ w_expected;
  assign w_accept   = bus.start && (r_state == S_IDLE || r_state == S_DONE);

`ifdef GATE_SEQ_STOP_ON_FAIL_EN
  assign w_last = (r_vec == 2'd3) || (w_mismatch != 6'd0);
`else
  assign w_last = (r_vec == 2'd3);
`endif

  // NOTE: every state register uses non-blocking assignment so all of them
  // update together from values sampled before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_vec   <= 2'd0;
      r_cnt   <= 8'd0;
      r_a     <= 1'b0;
      r_b     <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_mask  <= 6'd0;
      r_fvec  <= 2'd0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_state <= S_SETTLE;
        r_vec   <= 2'd0;
        r_cnt   <= LOAD;
        r_a     <= 1'b0;
        r_b     <= 1'b0;
        r_busy  <= 1'b1;
        r_pass  <= 1'b0;
        r_mask  <= 6'd0;
        r_fvec  <= 2'd0;
      end else begin
        case (r_state)
          S_IDLE: ;
          S_SETTLE: begin
            if (r_cnt != 8'd0) begin
              r_cnt <= r_cnt - 8'd1;
            end else begin
              r_mask <= r_mask | w_mismatch;
              // An all-zero mask means no earlier vector of this run failed.
              if (w_mismatch != 6'd0 && r_mask == 6'd0) r_fvec <= r_vec;
              if (w_last) begin
                r_state <= S_DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_a     <= 1'b0;
                r_b     <= 1'b0;
                r_pass  <= ((r_mask | w_mismatch) == 6'd0);
              end else begin
                r_vec      <= r_vec + 2'd1;
                r_cnt      <= LOAD;
                {r_a, r_b} <= r_vec + 2'd1;
              end
            end
          end
          S_DONE: r_state <= S_IDLE;
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_a     <= 1'b0;
            r_b     <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.a_o       = r_a;
  assign bus.b_o       = r_b;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.pass      = r_pass;
  assign bus.fail_mask = r_mask;
  assign bus.fail_vec  = r_fvec;

endmodule
